// File: rtl/n_term_loopback_cfg_if.sv
// Configuration frame bus for the north terminator tile: one data row plus the
// column frame strobes, driven by the previous tile or the configuration controller.
interface n_term_loopback_cfg_if #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32
);
    logic [FrameBitsPerRow-1:0] FrameData;
    logic [MaxFramesPerCol-1:0] FrameStrobe;

    modport master (output FrameData, output FrameStrobe);
    modport slave  (input  FrameData, input  FrameStrobe);
endinterface

// File: rtl/n_term_loopback_cfg.sv
// North-edge terminator tile: loops N_in back onto S_out through per-output
// frame-configured selects, with optional one-cycle regeneration registers.
//
// state  | meaning
// UNCONF | out of reset, no configuration loaded, outputs quiet
// LOAD   | owned frame strobes active, config being written, outputs quiet
// ACTIVE | configuration complete, loopback mux drives S_out
module n_term_loopback_cfg #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int N_IN            = 36,
    parameter int N_OUT           = 36,
    parameter int CFG_BASE        = 0
) (
    input  logic                       UserCLK,
    input  logic                       RST_N,
    n_term_loopback_cfg_if.slave       cfg_bus,
    input  logic [N_IN-1:0]            N_in,
    output logic [N_OUT-1:0]           S_out,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                       UserCLKo,
    output logic                       CfgActive
);
    localparam int SEL_BITS       = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int F              = SEL_BITS + 1;
    localparam int CFG_USED       = N_OUT * F;
    localparam int NUM_CFG_FRAMES = (CFG_USED + FrameBitsPerRow - 1) / FrameBitsPerRow;
    localparam int CFG_W          = NUM_CFG_FRAMES * FrameBitsPerRow;

    if (CFG_BASE + NUM_CFG_FRAMES > MaxFramesPerCol) begin : g_cfg_range_err
        $error("n_term_loopback_cfg: CFG_BASE+NUM_CFG_FRAMES exceeds MaxFramesPerCol");
    end

    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CFG_W-1:0]           cfg_q, cfg_d;
    logic [N_OUT-1:0]           pipe_q, pipe_d;
    logic [N_OUT-1:0]           src;
    logic [NUM_CFG_FRAMES-1:0]  frame_we;
    logic                       cs;
    logic                       out_en;

    assign FrameData_O   = cfg_bus.FrameData;
    assign FrameStrobe_O = cfg_bus.FrameStrobe;
    assign UserCLKo      = UserCLK;

    assign frame_we = cfg_bus.FrameStrobe[CFG_BASE +: NUM_CFG_FRAMES];
    assign cs       = |frame_we;

    // Overlapping strobes all take the same row.
    always_comb begin
        cfg_d = cfg_q;
        for (int k = 0; k < NUM_CFG_FRAMES; k++) begin
            if (frame_we[k]) begin
                cfg_d[k*FrameBitsPerRow +: FrameBitsPerRow] = cfg_bus.FrameData;
            end
        end
    end

    always_ff @(posedge UserCLK or negedge RST_N) begin
        if (!RST_N) begin
            cfg_q <= '0;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    if (CFG_W > CFG_USED) begin : g_cfg_spare
        logic cfg_spare_unused;
        assign cfg_spare_unused = ^cfg_q[CFG_W-1:CFG_USED];
    end

    always_ff @(posedge UserCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= UNCONF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNCONF:  if (cs)  state_d = LOAD;
            LOAD:    if (!cs) state_d = ACTIVE;
            ACTIVE:  if (cs)  state_d = LOAD;
            default: state_d = UNCONF;
        endcase
    end

    always_comb begin
        out_en    = (state_q == ACTIVE);
        CfgActive = out_en;
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        logic [SEL_BITS-1:0] sel;
        logic                regen;

        assign sel      = cfg_q[j*F +: SEL_BITS];
        assign regen    = cfg_q[j*F + SEL_BITS];
        assign src[j]   = (int'(sel) < N_IN) ? N_in[sel] : 1'b0;
        assign S_out[j] = out_en & (regen ? pipe_q[j] : src[j]);
    end

    // Pipes clear on the edge that leaves or enters ACTIVE, so a fresh mapping
    // never shows data sampled under the previous one.
    always_comb begin
        pipe_d = '0;
        if (state_q == ACTIVE && state_d == ACTIVE) begin
            pipe_d = src;
        end
    end

    always_ff @(posedge UserCLK or negedge RST_N) begin
        if (!RST_N) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end
endmodule

// File: tb/tb_n_term_loopback_cfg.sv
// Directed bench for n_term_loopback_cfg: reset, identity load, registered path,
// out-of-range select, reconfiguration and reset during load.
module tb_n_term_loopback_cfg;
    logic        UserCLK = 1'b0;
    logic        RST_N;
    logic [35:0] N_in;
    logic [35:0] S_out;
    logic [31:0] FrameData_O;
    logic [19:0] FrameStrobe_O;
    logic        UserCLKo;
    logic        CfgActive;

    int n_cmp = 0;
    int n_bad = 0;

    logic [255:0] img_id;
    logic [255:0] img_reg;

    n_term_loopback_cfg_if #(.MaxFramesPerCol(20), .FrameBitsPerRow(32)) cfg_bus ();

    n_term_loopback_cfg dut (
        .UserCLK      (UserCLK),
        .RST_N        (RST_N),
        .cfg_bus      (cfg_bus),
        .N_in         (N_in),
        .S_out        (S_out),
        .FrameData_O  (FrameData_O),
        .FrameStrobe_O(FrameStrobe_O),
        .UserCLKo     (UserCLKo),
        .CfgActive    (CfgActive)
    );

    always #5 UserCLK = ~UserCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic load_frames(input logic [255:0] img);
        N_in = 36'hF_FFFF_FFFF;
        for (int k = 0; k < 8; k++) begin
            cfg_bus.FrameStrobe = 20'(1) << k;
            cfg_bus.FrameData   = img[k*32 +: 32];
            step();
            check("load_cfgactive", 64'(CfgActive), 64'd0);
            check("load_quiet", 64'(S_out), 64'd0);
        end
        cfg_bus.FrameStrobe = '0;
        cfg_bus.FrameData   = '0;
        #1;
        check("load_pre_active", 64'(CfgActive), 64'd0);
        step();
        check("load_active", 64'(CfgActive), 64'd1);
    endtask

    initial begin
        RST_N               = 1'b0;
        N_in                = '0;
        cfg_bus.FrameData   = '0;
        cfg_bus.FrameStrobe = '0;

        img_id = '0;
        for (int j = 0; j < 36; j++) img_id[j*7 +: 7] = 7'(j);
        img_reg = img_id;
        img_reg[0*7 +: 7] = 7'h43;
        img_reg[5*7 +: 7] = 7'h3F;

        // Reset held, inputs toggling, pass-throughs live
        for (int i = 0; i < 4; i++) begin
            N_in                = (i % 2 == 0) ? 36'hF_FFFF_FFFF : 36'h5_A5A5_A5A5;
            cfg_bus.FrameData   = $urandom;
            cfg_bus.FrameStrobe = 20'($urandom);
            step();
            check("rst_sout", 64'(S_out), 64'd0);
            check("rst_cfgactive", 64'(CfgActive), 64'd0);
            check("rst_fdata_o", 64'(FrameData_O), 64'(cfg_bus.FrameData));
            check("rst_fstrobe_o", 64'(FrameStrobe_O), 64'(cfg_bus.FrameStrobe));
        end
        check("clko_high", 64'(UserCLKo), 64'd1);
        @(negedge UserCLK);
        #1;
        check("clko_low", 64'(UserCLKo), 64'd0);

        cfg_bus.FrameStrobe = '0;
        RST_N = 1'b1;
        N_in  = 36'hF_FFFF_FFFF;
        step();
        check("unconf_cfgactive", 64'(CfgActive), 64'd0);
        check("unconf_sout", 64'(S_out), 64'd0);

        // Identity combinational mapping
        load_frames(img_id);
        N_in = 36'h5_A5A5_A5A5;
        #1;
        check("ident_a5", 64'(S_out), 64'h5_A5A5_A5A5);
        N_in = 36'hA_5A5A_5A5A;
        #1;
        check("ident_5a", 64'(S_out), 64'hA_5A5A_5A5A);
        N_in = 36'h8_0000_0001;
        #1;
        check("ident_edges", 64'(S_out), 64'h8_0000_0001);

        // Out 0 registered from N_in[3], out 5 unselected
        load_frames(img_reg);
        N_in = 36'hF_FFFF_FFFF;
        #1;
        check("reg_first_cycle", 64'(S_out), 64'hF_FFFF_FFDE);
        step();
        check("reg_first_sample", 64'(S_out), 64'hF_FFFF_FFDF);
        N_in = '0;
        step();
        check("reg_idle", 64'(S_out), 64'd0);
        N_in = 36'h0_0000_0008;
        #1;
        check("reg_pulse_comb", 64'(S_out), 64'h8);
        step();
        N_in = '0;
        #1;
        check("reg_pulse_late", 64'(S_out), 64'h1);
        step();
        check("reg_pulse_end", 64'(S_out), 64'd0);

        N_in = 36'h0_0000_0020;
        step();
        check("oor_bit5_only", 64'(S_out), 64'd0);
        N_in = 36'h0_0000_0028;
        step();
        check("oor_bits35", 64'(S_out), 64'h9);

        // Reconfigure frame 2 to zero while active
        cfg_bus.FrameStrobe = 20'(1) << 2;
        cfg_bus.FrameData   = '0;
        N_in = 36'hF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reconf_quiet", 64'(S_out), 64'd0);
            check("reconf_cfgactive", 64'(CfgActive), 64'd0);
        end
        cfg_bus.FrameStrobe = '0;
        #1;
        check("reconf_pre_active", 64'(CfgActive), 64'd0);
        step();
        check("reconf_active", 64'(CfgActive), 64'd1);
        N_in = 36'h0_0000_0001;
        step();
        check("reconf_map_bit0", 64'(S_out), 64'h3C00);
        N_in = 36'h0_0000_0002;
        step();
        check("reconf_map_bit1", 64'(S_out), 64'h202);

        // Reset in the middle of a load
        cfg_bus.FrameStrobe = 20'h0000F;
        cfg_bus.FrameData   = 32'hFFFF_FFFF;
        step();
        step();
        #2;
        RST_N = 1'b0;
        #1;
        check("rstload_cfgactive", 64'(CfgActive), 64'd0);
        check("rstload_sout", 64'(S_out), 64'd0);
        step();
        step();
        check("rstload_held", 64'(S_out), 64'd0);
        cfg_bus.FrameStrobe = '0;
        RST_N = 1'b1;
        step();
        check("rstload_unconf", 64'(CfgActive), 64'd0);
        check("rstload_unconf_sout", 64'(S_out), 64'd0);
        cfg_bus.FrameStrobe = 20'(1) << 7;
        cfg_bus.FrameData   = '0;
        step();
        check("rstload_load", 64'(CfgActive), 64'd0);
        check("rstload_load_sout", 64'(S_out), 64'd0);
        cfg_bus.FrameStrobe = '0;
        step();
        check("rstload_active", 64'(CfgActive), 64'd1);
        N_in = 36'h0_0000_0001;
        #1;
        check("rstload_cfg_zero_1", 64'(S_out), 64'hF_FFFF_FFFF);
        N_in = 36'hF_FFFF_FFFE;
        #1;
        check("rstload_cfg_zero_0", 64'(S_out), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
